// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter FSM states and grant owner encodings shared by mem_arbiter and mem_arb_pick
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_VID  = 2'd1;
  localparam logic [1:0] GNT_CPU  = 2'd2;
  localparam logic [1:0] GNT_DSK  = 2'd3;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: bounded video priority plus cpu/disk round-robin; vid_cnt and rr_last advance on each arb-strobed grant
module mem_arb_pick import mem_arb_pkg::*; #(
  parameter int VID_BURST = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       arb,
  input  logic       vid_req,
  input  logic       cpu_req,
  input  logic       dsk_req,
  output logic [1:0] win
);
  localparam int CW = $clog2(VID_BURST + 1);
  logic [CW-1:0] vid_cnt;
  logic [1:0] rr_last, cd;
  logic other;
  always_comb begin
    other = cpu_req | dsk_req;
    cd = (cpu_req && dsk_req) ? ((rr_last == GNT_CPU) ? GNT_DSK : GNT_CPU) :
         cpu_req ? GNT_CPU : dsk_req ? GNT_DSK : GNT_NONE;
    win = (vid_req && (vid_cnt < CW'(VID_BURST) || !other)) ? GNT_VID : cd;
  end
  // video can only win with others pending while below the burst limit, so the increment never overflows
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      vid_cnt <= '0;
      rr_last <= GNT_CPU;
    end else if (arb && win != GNT_NONE) begin
      if (win == GNT_VID) vid_cnt <= other ? vid_cnt + 1'b1 : '0;
      else begin
        vid_cnt <= '0;
        rr_last <= win;
      end
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: request/grant/ack scheduler sharing one memory port among video, cpu and disk requesters.
// Define MEM_ARB_TIMEOUT_EN to add a mem_ack watchdog that completes the access with all-ones data and mem_err.
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 16,
  parameter int VID_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vid_req,
  input  logic              cpu_req,
  input  logic              dsk_req,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] dsk_addr,
  input  logic              cpu_we,
  input  logic              dsk_we,
  input  logic [1:0]        cpu_sel,
  input  logic [1:0]        dsk_sel,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [DATA_W-1:0] dsk_wdata,
  output logic              vid_ack,
  output logic              cpu_ack,
  output logic              dsk_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        grant,
  output logic              mem_err
);
  state_t state;
  logic [1:0] win;
  logic tmo_hit;
  mem_arb_pick #(.VID_BURST(VID_BURST)) u_pick (
    .clk(clk), .reset_n(reset_n), .arb(state == IDLE),
    .vid_req(vid_req), .cpu_req(cpu_req), .dsk_req(dsk_req), .win(win)
  );
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] tmo;
  logic err_q;
  assign tmo_hit = (state == WAIT) && !mem_ack && (tmo == 8'(TIMEOUT - 1));
  assign mem_err = err_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tmo <= '0;
      err_q <= 1'b0;
    end else begin
      tmo <= (state == WAIT) ? tmo + 1'b1 : '0;
      err_q <= tmo_hit;
    end
`else
  assign tmo_hit = 1'b0;
  assign mem_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      grant <= GNT_NONE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_sel <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dsk_ack <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dsk_ack <= 1'b0;
      case (state)
        IDLE: begin
          grant <= win;
          if (win != GNT_NONE) begin
            state <= ISSUE;
            mem_req <= 1'b1;
            mem_we <= (win == GNT_CPU) ? cpu_we : (win == GNT_DSK) ? dsk_we : 1'b0;
            mem_sel <= (win == GNT_CPU) ? cpu_sel : (win == GNT_DSK) ? dsk_sel : 2'b11;
            mem_addr <= (win == GNT_VID) ? vid_addr : (win == GNT_CPU) ? cpu_addr : dsk_addr;
            mem_wdata <= (win == GNT_CPU) ? cpu_wdata : (win == GNT_DSK) ? dsk_wdata : '0;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: if (mem_ack || tmo_hit) begin
          rdata <= mem_ack ? mem_rdata : '1;
          mem_req <= 1'b0;
          state <= DONE;
          vid_ack <= grant == GNT_VID;
          cpu_ack <= grant == GNT_CPU;
          dsk_ack <= grant == GNT_DSK;
        end
        DONE: begin
          state <= IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a delayed-ack memory model
module tb_mem_arbiter;
  localparam int AW = 25, DW = 16;
  logic clk = 1'b0, reset_n;
  logic vid_req, cpu_req, dsk_req, cpu_we, dsk_we;
  logic [AW-1:0] vid_addr, cpu_addr, dsk_addr;
  logic [1:0] cpu_sel, dsk_sel;
  logic [DW-1:0] cpu_wdata, dsk_wdata;
  logic vid_ack, cpu_ack, dsk_ack, mem_req, mem_we, mem_ack, mem_err;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [1:0] mem_sel, grant;
  logic [AW-1:0] mem_addr;
  always #5 clk = ~clk;
  mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .vid_req(vid_req), .cpu_req(cpu_req), .dsk_req(dsk_req),
    .vid_addr(vid_addr), .cpu_addr(cpu_addr), .dsk_addr(dsk_addr), .cpu_we(cpu_we), .dsk_we(dsk_we),
    .cpu_sel(cpu_sel), .dsk_sel(dsk_sel), .cpu_wdata(cpu_wdata), .dsk_wdata(dsk_wdata),
    .vid_ack(vid_ack), .cpu_ack(cpu_ack), .dsk_ack(dsk_ack), .rdata(rdata), .mem_req(mem_req),
    .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .mem_err(mem_err)
  );
  typedef struct {
    logic [1:0] g;
    logic we;
    logic [1:0] sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;
  int ack_dly = 3, cnt = 0;
  bit hold_ack = 0;
  logic req_q = 1'b0, mack_q = 1'b0;
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return a[15:0] ^ 16'hB5A5;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push(input logic [1:0] g, input logic we, input logic [1:0] sel, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input logic err);
    exp_t x;
    x.g = g; x.we = we; x.sel = sel; x.addr = addr; x.wd = wd; x.rd = rd; x.err = err;
    q.push_back(x);
  endtask
  task automatic wait_acks(input string tag, input int n);
    int seen = 0;
    for (int c = 0; c < 400 && seen < n; c++) begin
      @(negedge clk);
      if (vid_ack | cpu_ack | dsk_ack) seen++;
    end
    chk(tag, seen, n);
  endtask
  // memory controller model: acks ack_dly cycles after mem_req rises, data derived from the address
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mem_ack <= 1'b0;
      mem_rdata <= '0;
      cnt <= 0;
    end else begin
      mem_ack <= 1'b0;
      if (mem_req && !mem_ack && !hold_ack) begin
        if (cnt == ack_dly - 1) begin
          mem_ack <= 1'b1;
          mem_rdata <= mem_fn(mem_addr);
          cnt <= 0;
        end else cnt <= cnt + 1;
      end else cnt <= 0;
    end
  always @(negedge clk) begin
    if (mem_req && !req_q) begin
      if (q.size() == 0) chk("issue_unexpected", q.size(), 1);
      else begin
        chk("issue_grant", grant, q[0].g);
        chk("issue_we", mem_we, q[0].we);
        chk("issue_sel", mem_sel, q[0].sel);
        chk("issue_addr", mem_addr, q[0].addr);
        chk("issue_wdata", mem_wdata, q[0].wd);
      end
    end
    if (mem_ack && q.size() != 0) chk("hold_addr", mem_addr, q[0].addr);
    if (vid_ack | cpu_ack | dsk_ack) begin
      if (q.size() == 0) chk("ack_unexpected", {vid_ack, cpu_ack, dsk_ack}, 3'b000);
      else begin
        e = q.pop_front();
        chk("ack_owner", {vid_ack, cpu_ack, dsk_ack}, {e.g == 2'd1, e.g == 2'd2, e.g == 2'd3});
        chk("ack_rdata", rdata, e.rd);
        chk("ack_err", mem_err, e.err);
        chk("ack_mem_req_low", mem_req, 0);
        if (!e.err) chk("ack_latency", mack_q, 1);
      end
    end
    req_q = mem_req;
    mack_q = mem_ack;
  end
  initial begin
    int c;
    reset_n = 1'b0;
    {vid_req, cpu_req, dsk_req, cpu_we, dsk_we} = '0;
    {vid_addr, cpu_addr, dsk_addr, cpu_wdata, dsk_wdata} = '0;
    cpu_sel = 2'b11;
    dsk_sel = 2'b11;
    repeat (3) @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {vid_ack, cpu_ack, dsk_ack, mem_err}, 0);
    chk("rst_rdata", rdata, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_grant", grant, 0);
    cpu_addr = 25'h1000;
    push(2'd2, 1'b0, 2'b11, 25'h1000, 16'h0, 16'hA5A5, 1'b0);
    cpu_req = 1'b1;
    @(negedge clk);
    chk("t1_mem_req_cycle1", mem_req, 1);
    chk("t1_grant", grant, 2);
    wait_acks("t1_acks", 1);
    chk("t1_rdata", rdata, 16'hA5A5);
    cpu_req = 1'b0;
    dsk_addr = 25'h0ABCD; dsk_we = 1'b1; dsk_sel = 2'b01; dsk_wdata = 16'h00FF;
    push(2'd3, 1'b1, 2'b01, 25'h0ABCD, 16'h00FF, mem_fn(25'h0ABCD), 1'b0);
    dsk_req = 1'b1;
    c = 0;
    while (grant != 2'd3 && c < 20) begin @(negedge clk); c++; end
    chk("t4_granted", grant, 3);
    dsk_req = 1'b0;
    wait_acks("t4_acks", 1);
    repeat (3) @(negedge clk);
    chk("t4_single_ack", {vid_ack, cpu_ack, dsk_ack}, 0);
    dsk_we = 1'b0; dsk_sel = 2'b11; dsk_wdata = '0;
    ack_dly = 2;
    cpu_addr = 25'h0200; dsk_addr = 25'h0300;
    for (int i = 0; i < 3; i++) begin
      push(2'd2, 1'b0, 2'b11, 25'h0200, 16'h0, mem_fn(25'h0200), 1'b0);
      push(2'd3, 1'b0, 2'b11, 25'h0300, 16'h0, mem_fn(25'h0300), 1'b0);
    end
    cpu_req = 1'b1; dsk_req = 1'b1;
    wait_acks("t2_acks", 6);
    cpu_req = 1'b0; dsk_req = 1'b0;
    @(negedge clk);
    vid_addr = 25'h1ABCD; cpu_addr = 25'h0400;
    for (int i = 0; i < 4; i++) push(2'd1, 1'b0, 2'b11, 25'h1ABCD, 16'h0, mem_fn(25'h1ABCD), 1'b0);
    push(2'd2, 1'b0, 2'b11, 25'h0400, 16'h0, mem_fn(25'h0400), 1'b0);
    push(2'd1, 1'b0, 2'b11, 25'h1ABCD, 16'h0, mem_fn(25'h1ABCD), 1'b0);
    vid_req = 1'b1; cpu_req = 1'b1;
    wait_acks("t3_acks", 6);
    vid_req = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    ack_dly = 1;
    for (int i = 0; i < 5; i++) push(2'd1, 1'b0, 2'b11, 25'h1ABCD, 16'h0, mem_fn(25'h1ABCD), 1'b0);
    vid_req = 1'b1;
    wait_acks("vid_alone_acks", 5);
    vid_req = 1'b0;
    @(negedge clk);
    hold_ack = 1;
    cpu_addr = 25'h0777;
    push(2'd2, 1'b0, 2'b11, 25'h0777, 16'h0, mem_fn(25'h0777), 1'b0);
    cpu_req = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_in_wait", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("t5_async_mem_req", mem_req, 0);
    chk("t5_async_grant", grant, 0);
    cpu_req = 1'b0;
    q.delete();
    hold_ack = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_ack", {vid_ack, cpu_ack, dsk_ack}, 0);
    ack_dly = 3;
    cpu_addr = 25'h0777; dsk_addr = 25'h0888;
    push(2'd3, 1'b0, 2'b11, 25'h0888, 16'h0, mem_fn(25'h0888), 1'b0);
    push(2'd2, 1'b0, 2'b11, 25'h0777, 16'h0, mem_fn(25'h0777), 1'b0);
    cpu_req = 1'b1; dsk_req = 1'b1;
    wait_acks("t5_after_reset_acks", 2);
    cpu_req = 1'b0; dsk_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clk);
    hold_ack = 1;
    cpu_addr = 25'h0042;
    push(2'd2, 1'b0, 2'b11, 25'h0042, 16'h0, 16'hFFFF, 1'b1);
    cpu_req = 1'b1;
    @(negedge clk);
    chk("tmo_mem_req", mem_req, 1);
    c = 0;
    while (!cpu_ack && c < 300) begin @(negedge clk); c++; end
    chk("tmo_cycles", c, 256);
    cpu_req = 1'b0;
    hold_ack = 0;
    repeat (4) @(negedge clk);
    chk("tmo_no_late_ack", {vid_ack, cpu_ack, dsk_ack, mem_err}, 0);
`endif
    repeat (4) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
